lsu_wb: RTL and testbench

- Multi-cycle load/store unit. It takes a memory op from execute: address, store data read from register-file port 2, and destination register.
- It runs a valid/ready request and response handshake with data memory.
- For loads it drives the register-file write port (wen/waddr/wdata) with the aligned, extended result.
- It sits directly upstream of the register file's write port. A single-issue core stalls on in_ready.

---
 rtl/lsu_wb_if.sv | 24 ++
 rtl/lsu_wb.sv | 165 ++++++++++++++++
 tb/tb_lsu_wb.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_wb_if.sv
// Data-memory request/response bus between the load/store unit and memory.
// master is the unit side, slave the memory side.
interface lsu_wb_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [DATA_WIDTH-1:0] mem_req_addr;
   logic                  mem_req_wen;
   logic [DATA_WIDTH-1:0] mem_req_wdata;
   logic [3:0]            mem_req_wstrb;
   logic                  mem_resp_valid;
   logic [DATA_WIDTH-1:0] mem_resp_data;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/lsu_wb.sv
// Multi-cycle load/store unit: one memory op at a time, load results
// aligned/extended and written to the register-file write port.
module lsu_wb #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_store,
   input  logic [2:0]            in_funct3,
   input  logic [DATA_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_wdata,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   lsu_wb_if.master              mem,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  done,
   output logic                  err
);
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {IDLE, REQ, RESP, WB, DONE, ERR} state_t;

   state_t                state, state_nxt;
   logic                  accept, illegal;
   logic [1:0]            off_in;
   logic [3:0]            strb_in;
   logic [DATA_WIDTH-1:0] lane_wdata;
   logic                  store_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] req_addr, req_wdata;
   logic [3:0]            req_wstrb;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [DATA_WIDTH-1:0] load_ext;

   assign accept = in_valid && (state == IDLE);
   assign off_in = in_addr[1:0];

   // Legality and store lane placement, evaluated on the offered op
   always_comb begin
      illegal    = 1'b0;
      strb_in    = 4'b0000;
      lane_wdata = in_wdata;
      case (in_funct3)
         F3_B:    illegal = 1'b0;
         F3_H:    illegal = off_in[0];
         F3_W:    illegal = (off_in != 2'd0);
         F3_BU:   illegal = in_store;
         F3_HU:   illegal = in_store || off_in[0];
         default: illegal = 1'b1;
      endcase
      case (in_funct3[1:0])
         2'b00: begin
            strb_in    = 4'b0001 << off_in;
            lane_wdata = {4{in_wdata[7:0]}};
         end
         2'b01: begin
            strb_in    = 4'b0011 << off_in;
            lane_wdata = {2{in_wdata[15:0]}};
         end
         default: strb_in = 4'b1111;
      endcase
      if (!in_store) strb_in = 4'b0000;
   end

   // Extract and extend the addressed byte/half from the response word
   always_comb begin
      case (off_q)
         2'd0:    byte_v = mem.mem_resp_data[7:0];
         2'd1:    byte_v = mem.mem_resp_data[15:8];
         2'd2:    byte_v = mem.mem_resp_data[23:16];
         default: byte_v = mem.mem_resp_data[31:24];
      endcase
      half_v = off_q[1] ? mem.mem_resp_data[31:16] : mem.mem_resp_data[15:0];
      case (funct3_q)
         F3_B:    load_ext = {{24{byte_v[7]}}, byte_v};
         F3_H:    load_ext = {{16{half_v[15]}}, half_v};
         F3_BU:   load_ext = {24'd0, byte_v};
         F3_HU:   load_ext = {16'd0, half_v};
         default: load_ext = mem.mem_resp_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = illegal ? ERR : REQ;
         REQ:     if (mem.mem_req_ready) state_nxt = RESP;
         RESP:    if (mem.mem_resp_valid) state_nxt = store_q ? DONE : WB;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready          = 1'b0;
      mem.mem_req_valid = 1'b0;
      rf_wen            = 1'b0;
      done              = 1'b0;
      err               = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         REQ:  mem.mem_req_valid = 1'b1;
         WB: begin
            rf_wen = (rd_q != '0);
            done   = 1'b1;
         end
         DONE: done = 1'b1;
         ERR: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

   // Op capture at accept; register port updates only on a real write so
   // rf_waddr/rf_wdata hold their last written values otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         store_q   <= 1'b0;
         funct3_q  <= 3'd0;
         off_q     <= 2'd0;
         rd_q      <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_wstrb <= 4'd0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
      end else begin
         if (accept) begin
            store_q   <= in_store;
            funct3_q  <= in_funct3;
            off_q     <= off_in;
            rd_q      <= in_rd;
            req_addr  <= {in_addr[DATA_WIDTH-1:2], 2'b00};
            req_wdata <= lane_wdata;
            req_wstrb <= strb_in;
         end
         if (state == RESP && mem.mem_resp_valid && !store_q && rd_q != '0) begin
            rf_waddr <= rd_q;
            rf_wdata <= load_ext;
         end
      end
   end

   assign mem.mem_req_addr  = req_addr;
   assign mem.mem_req_wen   = store_q;
   assign mem.mem_req_wdata = req_wdata;
   assign mem.mem_req_wstrb = req_wstrb;
endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: directed vector table, reset-abort sequence and random
// ops checked against an arithmetic reference model.
module tb_lsu_wb;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        rf_wen, done, err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks = 0;
   int failures = 0;
   logic [4:0]  last_addr;
   logic [31:0] last_data;

   lsu_wb_if #(.DATA_WIDTH(32)) mem_bus ();

   lsu_wb #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem(mem_bus),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic [31:0] resp;
      int          rq_wait;
      int          rs_wait;
      logic        e_err;
      logic [3:0]  e_strb;
      logic [31:0] e_mwd;
      logic [31:0] e_rf;
   } vec_t;

   typedef struct {
      logic        err;
      logic [3:0]  strb;
      logic [31:0] mwd;
      logic [31:0] rf;
   } model_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Reference: size-based alignment, multiply-replicated store lanes,
   // shift/mask load extraction with two's-complement sign fix-up
   function automatic model_t model(input logic st, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [31:0] resp);
      model_t     m;
      int         size;
      int         off;
      bit         legal;
      longint     mask;
      longint     v;
      size  = 1 << f3[1:0];
      off   = int'(addr % 4);
      legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      m.err = !legal || (int'(addr % 32'(size)) != 0);
      mask  = (64'd1 << (8 * size)) - 1;
      m.strb = st ? 4'(((1 << size) - 1) << off) : 4'd0;
      if (size >= 4) m.mwd = wd;
      else m.mwd = 32'((longint'(wd) & mask) * ((size == 1) ? 64'h01010101 : 64'h00010001));
      v = (longint'(resp) >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v > (mask >> 1)) v = v - (mask + 1);
      m.rf = 32'(v);
      return m;
   endfunction

   task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] resp, input int rq_wait, input int rs_wait,
                         input logic e_err, input logic [3:0] e_strb,
                         input logic [31:0] e_mwd, input logic [31:0] e_rf);
      int phase = 0, wcnt = 0, rcnt = rs_wait, lat = 0, nreq = 0, nwen = 0;
      bit stable = 1, got_done = 0;
      logic        o_err = 1'b0, o_wen = 1'b0;
      logic [4:0]  o_waddr = '0;
      logic [31:0] o_wdata = '0, o_addr = '0, o_wdat = '0;
      logic [3:0]  o_strb = '0;
      bit          exp_wr;
      exp_wr = !st && !e_err && (rd != 5'd0);
      @(negedge clk);
      chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_store = st; in_funct3 = f3; in_addr = addr; in_wdata = wd; in_rd = rd;
      for (int c = 1; c <= 60 && !got_done; c++) begin
         @(negedge clk);
         if (c == 1) begin
            in_valid = 1'b0; in_store = 1'($urandom); in_funct3 = 3'($urandom);
            in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
         end
         mem_bus.mem_req_ready  = 1'b0;
         mem_bus.mem_resp_valid = 1'b0;
         mem_bus.mem_resp_data  = $urandom;
         if (rf_wen) begin nwen++; o_waddr = rf_waddr; o_wdata = rf_wdata; end
         if (done) begin got_done = 1; lat = c; o_err = err; end
         if (mem_bus.mem_req_valid) begin
            if (nreq == 0) begin
               o_addr = mem_bus.mem_req_addr; o_wen = mem_bus.mem_req_wen;
               o_strb = mem_bus.mem_req_wstrb; o_wdat = mem_bus.mem_req_wdata;
            end else if (o_addr !== mem_bus.mem_req_addr || o_wen !== mem_bus.mem_req_wen ||
                         o_strb !== mem_bus.mem_req_wstrb || o_wdat !== mem_bus.mem_req_wdata)
               stable = 0;
            nreq++;
         end
         case (phase)
            0: if (mem_bus.mem_req_valid) begin
                  mem_bus.mem_resp_valid = 1'($urandom_range(0, 1));
                  if (wcnt == rq_wait) begin mem_bus.mem_req_ready = 1'b1; phase = 1; end
                  else wcnt++;
               end
            1: if (rcnt == 0) begin
                  mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_data = resp; phase = 2;
               end else rcnt--;
            default: ;
         endcase
      end
      if (!got_done) chk({tag, " timeout_done"}, 32'd0, 32'd1);
      chk({tag, " latency"}, 32'(lat), e_err ? 32'd1 : 32'(3 + rq_wait + rs_wait));
      chk({tag, " err"}, 32'(o_err), 32'(e_err));
      chk({tag, " req_cycles"}, 32'(nreq), e_err ? 32'd0 : 32'(rq_wait + 1));
      if (!e_err) begin
         chk({tag, " req_addr"}, o_addr, addr & 32'hFFFF_FFFC);
         chk({tag, " req_wen"}, 32'(o_wen), 32'(st));
         chk({tag, " req_wstrb"}, 32'(o_strb), 32'(e_strb));
         if (st) chk({tag, " req_wdata"}, o_wdat, e_mwd);
         chk({tag, " req_stable"}, 32'(stable), 32'd1);
      end
      chk({tag, " rf_wen_count"}, 32'(nwen), exp_wr ? 32'd1 : 32'd0);
      if (exp_wr) begin
         chk({tag, " rf_waddr"}, 32'(o_waddr), 32'(rd));
         chk({tag, " rf_wdata"}, o_wdata, e_rf);
         last_addr = rd; last_data = e_rf;
      end
      @(negedge clk);
      chk({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, " rf_wdata_hold"}, rf_wdata, last_data);
      chk({tag, " rf_waddr_hold"}, 32'(rf_waddr), 32'(last_addr));
   endtask

   vec_t   tbl[13];
   model_t m;

   initial begin
      tbl[0]  = '{1'b0, 3'd2, 32'h8000_0010, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF};
      tbl[1]  = '{1'b0, 3'd0, 32'h8000_0013, 32'h0, 5'd6, 32'h8011_2233, 0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80};
      tbl[2]  = '{1'b0, 3'd4, 32'h8000_0013, 32'h0, 5'd7, 32'h8011_2233, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0000_0080};
      tbl[3]  = '{1'b0, 3'd1, 32'h8000_0012, 32'h0, 5'd8, 32'h8011_2233, 0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF_8011};
      tbl[4]  = '{1'b0, 3'd5, 32'h8000_0012, 32'h0, 5'd9, 32'h8011_2233, 1, 1, 1'b0, 4'h0, 32'h0, 32'h0000_8011};
      tbl[5]  = '{1'b1, 3'd0, 32'h0000_0101, 32'h0000_00AB, 5'd3, 32'h0, 3, 2, 1'b0, 4'h2, 32'hABAB_ABAB, 32'h0};
      tbl[6]  = '{1'b1, 3'd1, 32'h0000_0102, 32'h1234_CAFE, 5'd4, 32'h0, 1, 0, 1'b0, 4'hC, 32'hCAFE_CAFE, 32'h0};
      tbl[7]  = '{1'b1, 3'd2, 32'h0000_0200, 32'h1234_5678, 5'd1, 32'h0, 0, 0, 1'b0, 4'hF, 32'h1234_5678, 32'h0};
      tbl[8]  = '{1'b0, 3'd2, 32'h0000_0102, 32'h0, 5'd10, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
      tbl[9]  = '{1'b1, 3'd1, 32'h0000_0101, 32'h0, 5'd11, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
      tbl[10] = '{1'b1, 3'd4, 32'h0000_0100, 32'h0, 5'd12, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
      tbl[11] = '{1'b0, 3'd2, 32'h0000_0040, 32'h0, 5'd0, 32'h55AA_55AA, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0};
      tbl[12] = '{1'b0, 3'd3, 32'h0000_0040, 32'h0, 5'd13, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};

      rst = 1'b1; in_valid = 1'b0; in_store = 1'b0; in_funct3 = 3'd0;
      in_addr = '0; in_wdata = '0; in_rd = '0;
      mem_bus.mem_req_ready = 1'b0; mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_data = '0;
      last_addr = '0; last_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
      chk("reset rf_wen", 32'(rf_wen), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset rf_wdata", rf_wdata, 32'd0);

      for (int i = 0; i < 13; i++)
         run_op($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd,
                tbl[i].resp, tbl[i].rq_wait, tbl[i].rs_wait, tbl[i].e_err, tbl[i].e_strb,
                tbl[i].e_mwd, tbl[i].e_rf);

      // Reset while waiting in RESP, then a stray response in IDLE
      @(negedge clk);
      in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'd2; in_addr = 32'h300; in_rd = 5'd15;
      @(negedge clk);
      in_valid = 1'b0; mem_bus.mem_req_ready = 1'b1;
      @(negedge clk);
      mem_bus.mem_req_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_data = 32'h1357_9BDF;
      last_addr = '0; last_data = '0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("abort rf_wen c%0d", k), 32'(rf_wen), 32'd0);
         chk($sformatf("abort done c%0d", k), 32'(done), 32'd0);
         chk($sformatf("abort in_ready c%0d", k), 32'(in_ready), 32'd1);
         @(negedge clk);
         mem_bus.mem_resp_valid = 1'b0;
      end
      chk("abort rf_wdata cleared", rf_wdata, 32'd0);
      run_op("post_abort", 1'b0, 3'd2, 32'h0000_0304, 32'h0, 5'd16, 32'h2468_ACE0, 0, 0,
             1'b0, 4'h0, 32'h0, 32'h2468_ACE0);

      for (int i = 0; i < 150; i++) begin
         logic        st;
         logic [2:0]  f3;
         logic [31:0] addr, wd, resp;
         logic [4:0]  rd;
         st = 1'($urandom); f3 = 3'($urandom_range(0, 7));
         addr = $urandom; wd = $urandom; resp = $urandom; rd = 5'($urandom);
         m = model(st, f3, addr, wd, resp);
         run_op($sformatf("rnd%0d", i), st, f3, addr, wd, rd, resp,
                $urandom_range(0, 3), $urandom_range(0, 3), m.err, m.strb, m.mwd, m.rf);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
